alu_arbiter: RTL and testbench

//  Shares the single combinational ALU (add/sub/and/or/nor/slt, Zero flag) between NREQ requesters.

---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for the shared ALU arbiter:
// operation request channel plus result response channel.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_ctrl;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_data;
  logic              rsp_zero;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters,
// one operation in flight: IDLE (grant) -> EXEC (settle) -> RESP.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int IDW  = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] grant;
  logic           found;
  logic [IDW:0]   idx;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [3:0]     sel_ctrl;

  // Scan from rr_ptr upward, wrapping at NREQ; first valid wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ))
        idx = idx - (IDW+1)'(NREQ);
      if (!found && bus.req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a    = bus.req_a[i*W +: W];
        sel_b    = bus.req_b[i*W +: W];
        sel_ctrl = bus.req_ctrl[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          bus.req_ready[grant] = 1'b1;
          state_nxt            = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        bus.rsp_valid[bus.rsp_id] = 1'b1;
        if (bus.rsp_ready[bus.rsp_id])
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands only move on a grant, so the ALU inputs hold between ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      owner        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctrl     <= 4'b0000;
      bus.rsp_data <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_id   <= '0;
    end else begin
      if (state == IDLE && found) begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_ctrl <= sel_ctrl;
        owner    <= grant;
        rr_ptr   <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end
      if (state == EXEC) begin
        bus.rsp_data <= alu_out;
        bus.rsp_zero <= alu_zero;
        bus.rsp_id   <= owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the
// alu_* side and hand-computed expectations per scenario.
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic         clk;
  logic         reset;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero;

  int checks;
  int errors;

  alu_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_zero (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = alu_a - alu_b;
      4'b0010: alu_out = alu_a & alu_b;
      4'b0011: alu_out = alu_a | alu_b;
      4'b0100: alu_out = ~(alu_a | alu_b);
      4'b1000: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] c);
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
    bus.req_ctrl[i*4 +: 4] = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rsp_data !== 32'd0 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_rsp: data=%h zero=%b id=%0d want 0",
               bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0 ||
          alu_ctrl !== 4'b0) begin
        errors++;
        $display("FAIL reset_idle c%0d: rdy=%b vld=%b ctrl=%b want 0",
                 c, bus.req_ready, bus.rsp_valid, alu_ctrl);
      end
      step();
    end
  endtask

  task automatic test_single();
    set_req(1, 32'd7, 32'd5, 4'b0001);
    bus.rsp_ready = 4'b0010;
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b want 0010", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0000;
    checks++;
    if (bus.rsp_valid !== 4'b0 || bus.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL single_exec: vld=%b rdy=%b want 0000",
               bus.rsp_valid, bus.req_ready);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'd2 ||
        bus.rsp_zero !== 1'b0 || bus.rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL single_rsp: vld=%b d=%0d z=%b id=%0d want 0010 2 0 1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_id);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_done: vld=%b want 0000", bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, W'(i), 32'd10, 4'b0000);
    bus.rsp_ready = 4'b1111;
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      checks++;
      if (bus.req_ready !== 4'(1 << e)) begin
        errors++;
        $display("FAIL rr_grant op%0d: got %b want %b",
                 k, bus.req_ready, 4'(1 << e));
      end
      step();
      checks++;
      if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 4'b0) begin
        errors++;
        $display("FAIL rr_exec op%0d: rdy=%b vld=%b want 0",
                 k, bus.req_ready, bus.rsp_valid);
      end
      step();
      checks++;
      if (bus.rsp_valid !== 4'(1 << e) || bus.rsp_data !== 32'(10 + e) ||
          bus.rsp_id !== 2'(e)) begin
        errors++;
        $display("FAIL rr_rsp op%0d: vld=%b d=%0d id=%0d want %b %0d %0d",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_id,
                 4'(1 << e), 10 + e, e);
      end
      step();
    end
    bus.req_valid = 4'b0;
    step();
  endtask

  task automatic test_backpressure();
    set_req(2, 32'h12345678, 32'h12345678, 4'b0001);
    set_req(0, 32'd20, 32'd22, 4'b0000);
    bus.rsp_ready = 4'b0000;
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0001;
    step();
    bus.rsp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 32'd0 ||
          bus.rsp_zero !== 1'b1 || bus.req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: vld=%b d=%h z=%b rdy=%b want 0100 0 1 0",
                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.req_ready);
      end
      step();
    end
    bus.rsp_ready = 4'b0100;
    step();
    bus.rsp_ready = 4'b0001;
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL bp_next: rdy=%b vld=%b want 0001 0000",
               bus.req_ready, bus.rsp_valid);
    end
    step();
    bus.req_valid = 4'b0;
    step();
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 32'd42) begin
      errors++;
      $display("FAIL bp_req0: vld=%b d=%0d want 0001 42",
               bus.rsp_valid, bus.rsp_data);
    end
    step();
  endtask

  task automatic test_ops();
    logic [3:0] c3 [3] = '{4'b1000, 4'b0100, 4'b1111};
    logic [W-1:0] a3 [3] = '{32'd3, 32'd0, 32'd6};
    logic [W-1:0] b3 [3] = '{32'd9, 32'd0, 32'd6};
    logic [W-1:0] d3 [3] = '{32'd1, 32'hFFFFFFFF, 32'd0};
    logic z3 [3] = '{1'b0, 1'b0, 1'b1};
    bus.rsp_ready = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      set_req(3, a3[k], b3[k], c3[k]);
      bus.req_valid = 4'b1000;
      #1;
      checks++;
      if (bus.req_ready !== 4'b1000) begin
        errors++;
        $display("FAIL ops_grant%0d: got %b want 1000", k, bus.req_ready);
      end
      step();
      bus.req_valid = 4'b0;
      step();
      checks++;
      if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== d3[k] ||
          bus.rsp_zero !== z3[k] || bus.rsp_id !== 2'd3 ||
          alu_ctrl !== c3[k]) begin
        errors++;
        $display("FAIL ops_rsp%0d: d=%h z=%b id=%0d ctrl=%b want %h %b 3 %b",
                 k, bus.rsp_data, bus.rsp_zero, bus.rsp_id, alu_ctrl,
                 d3[k], z3[k], c3[k]);
      end
      step();
      checks++;
      if (alu_a !== a3[k] || alu_ctrl !== c3[k]) begin
        errors++;
        $display("FAIL ops_hold%0d: a=%h ctrl=%b want %h %b",
                 k, alu_a, alu_ctrl, a3[k], c3[k]);
      end
    end
  endtask

  task automatic test_reset_inflight();
    set_req(0, 32'd1, 32'd1, 4'b0000);
    bus.rsp_ready = 4'b1111;
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_grant: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (alu_ctrl !== 4'b0 || alu_a !== 32'd0) begin
      errors++;
      $display("FAIL rst_alu: ctrl=%b a=%h want 0", alu_ctrl, alu_a);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.rsp_valid !== 4'b0) begin
        errors++;
        $display("FAIL rst_norsp c%0d: vld=%b want 0000", c, bus.rsp_valid);
      end
      step();
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rst_ptr: got %b want 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0;
    step();
    step();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1);
  end

endmodule
